aes_noamba_regif: RTL

//  Responder (slave) end of the AES no-AMBA register bus: decodes wr_amba/strb/data_in/addr_wc

---
 rtl/aes_noamba_regif_if.sv | 27 ++
 rtl/aes_noamba_regif.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/aes_noamba_regif_if.sv
// Bus between the AES no-AMBA register initiator and the responder.
//   wr_amba     write strobe, one write per cycle while high
//   strb        byte enables for data_in
//   data_in     write data
//   addr_wc     write byte address
//   addr_rc     read byte address
//   data_out    registered read data (1-cycle latency)
//   enable_amba 1 = responder idle, writes accepted, results valid
interface aes_noamba_regif_if;
    logic        wr_amba;
    logic [3:0]  strb;
    logic [31:0] data_in;
    logic [31:0] addr_wc;
    logic [31:0] addr_rc;
    logic [31:0] data_out;
    logic        enable_amba;

    modport master (
        output wr_amba, strb, data_in, addr_wc, addr_rc,
        input  data_out, enable_amba
    );

    modport slave (
        input  wr_amba, strb, data_in, addr_wc, addr_rc,
        output data_out, enable_amba
    );
endinterface

// File: rtl/aes_noamba_regif.sv
// Responder end of the AES no-AMBA register bus. Holds key/block/IV/conf,
// launches the AES core, captures its result and paces the initiator.
//
// Ports:
//   ACLK, ARSTn          clock / async active-low reset
//   bus (slave)          register bus, see aes_noamba_regif_if
//   core_key/block/iv    register contents to the core, word0 = bits[31:0]
//   core_mode, core_inv  conf[2:0], conf[3]
//   core_ctr             CTR-mode block counter
//   core_start           one-cycle launch pulse to the core
//   core_done            one-cycle done pulse, core_result valid same cycle
//   irq                  completion interrupt, only with AES_REGIF_IRQ_EN
//
// Optional feature macro: AES_REGIF_IRQ_EN (irq port and status.irq_pend).
//
// Register map (byte offset from BASE_ADDR):
//   00-0C key  10-1C block  20-2C iv  30-3C result (RO)
//   40 ctr (RO)  44 status {irq_pend,wr_err,busy} W1C  48 conf {start,ctr_rst,inv,mode}
//
// state | meaning
// IDLE  | bus writes accepted, enable_amba = 1
// START | core_start pulse, enable_amba = 0
// BUSY  | waiting for core_done
// CAPT  | result captured, enable_amba returns next edge
module aes_noamba_regif #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CTR_W     = 32
) (
    input  logic               ACLK,
    input  logic               ARSTn,
    aes_noamba_regif_if.slave  bus,
    output logic [127:0]       core_key,
    output logic [127:0]       core_block,
    output logic [127:0]       core_iv,
    output logic [2:0]         core_mode,
    output logic               core_inv,
    output logic [CTR_W-1:0]   core_ctr,
    output logic               core_start,
`ifdef AES_REGIF_IRQ_EN
    output logic               irq,
`endif
    input  logic               core_done,
    input  logic [127:0]       core_result
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_CAPT} state_t;

    state_t           state_q;
    logic [3:0][31:0] key_q, blk_q, iv_q, res_q;
    logic [3:0]       conf_q;
    logic [CTR_W-1:0] ctr_q;
    logic             wr_err_q;
    logic             irq_bit;

    logic [31:0] wr_off, rd_off, rd_data;
    logic        wr_acc, wr_arr, wr_status, wr_conf, wr_drop, launch, busy;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction

    assign wr_off    = bus.addr_wc - BASE_ADDR;
    assign rd_off    = bus.addr_rc - BASE_ADDR;
    assign busy      = (state_q != S_IDLE);
    // enable_amba is only ever high in IDLE, so it doubles as the accept gate
    assign wr_acc    = bus.wr_amba && bus.enable_amba;
    assign wr_arr    = (wr_off[31:6] == 26'd0) && (wr_off[1:0] == 2'b00);
    // status W1C bypasses the busy gate so software can always clear flags
    assign wr_status = bus.wr_amba && (wr_off == 32'h44);
    assign wr_conf   = wr_acc && (wr_off == 32'h48);
    assign wr_drop   = bus.wr_amba && busy && !wr_status;
    assign launch    = wr_conf && bus.data_in[31] && bus.strb[3];

`ifdef AES_REGIF_IRQ_EN
    logic irq_pend_q;
    assign irq_bit = irq_pend_q;
    assign irq     = irq_pend_q;
`else
    assign irq_bit = 1'b0;
`endif

    always_comb begin
        rd_data = 32'd0;
        if ((rd_off[31:7] == 25'd0) && (rd_off[1:0] == 2'b00)) begin
            case (rd_off[6:4])
                3'd0: rd_data = key_q[rd_off[3:2]];
                3'd1: rd_data = blk_q[rd_off[3:2]];
                3'd2: rd_data = iv_q[rd_off[3:2]];
                3'd3: rd_data = res_q[rd_off[3:2]];
                3'd4: begin
                    case (rd_off[3:2])
                        2'd0:    rd_data = 32'(ctr_q);
                        2'd1:    rd_data = {29'd0, irq_bit, wr_err_q, busy};
                        2'd2:    rd_data = {28'd0, conf_q};
                        default: rd_data = 32'd0;
                    endcase
                end
                default: rd_data = 32'd0;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            state_q         <= S_IDLE;
            key_q           <= '0;
            blk_q           <= '0;
            iv_q            <= '0;
            res_q           <= '0;
            conf_q          <= '0;
            ctr_q           <= '0;
            wr_err_q        <= 1'b0;
            core_start      <= 1'b0;
            bus.enable_amba <= 1'b0;
            bus.data_out    <= 32'd0;
`ifdef AES_REGIF_IRQ_EN
            irq_pend_q      <= 1'b0;
`endif
        end else begin
            bus.data_out <= rd_data;

            if (wr_acc && wr_arr) begin
                case (wr_off[5:4])
                    2'd0:    key_q[wr_off[3:2]] <= merge_bytes(key_q[wr_off[3:2]], bus.data_in, bus.strb);
                    2'd1:    blk_q[wr_off[3:2]] <= merge_bytes(blk_q[wr_off[3:2]], bus.data_in, bus.strb);
                    2'd2:    iv_q[wr_off[3:2]]  <= merge_bytes(iv_q[wr_off[3:2]], bus.data_in, bus.strb);
                    default: ;
                endcase
            end

            // start and ctr_rst are actions, only mode/inv are stored
            if (wr_conf && bus.strb[0]) begin
                conf_q <= bus.data_in[3:0];
                if (bus.data_in[4])
                    ctr_q <= '0;
            end

            if (wr_drop)
                wr_err_q <= 1'b1;
            else if (wr_status && bus.strb[0] && bus.data_in[1])
                wr_err_q <= 1'b0;

`ifdef AES_REGIF_IRQ_EN
            if (state_q == S_CAPT)
                irq_pend_q <= 1'b1;
            else if (wr_status && bus.strb[0] && bus.data_in[2])
                irq_pend_q <= 1'b0;
`endif

            case (state_q)
                S_IDLE: begin
                    bus.enable_amba <= 1'b1;
                    if (launch) begin
                        state_q         <= S_START;
                        core_start      <= 1'b1;
                        bus.enable_amba <= 1'b0;
                    end
                end
                S_START: begin
                    core_start <= 1'b0;
                    state_q    <= S_BUSY;
                end
                S_BUSY: begin
                    if (core_done) begin
                        res_q   <= core_result;
                        if (conf_q[2:0] == 3'd5)
                            ctr_q <= ctr_q + CTR_W'(1);
                        state_q <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    state_q         <= S_IDLE;
                    bus.enable_amba <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign core_key   = key_q;
    assign core_block = blk_q;
    assign core_iv    = iv_q;
    assign core_mode  = conf_q[2:0];
    assign core_inv   = conf_q[3];
    assign core_ctr   = ctr_q;

endmodule
